// File: rtl/mealy_step_pkg.sv
// Shared types and helpers for the programmable increment/shift Mealy sequencer.
package mealy_step_pkg;

  typedef enum logic {
    MODE_INC = 1'b0,
    MODE_SHL = 1'b1
  } mode_e;

  // One output entry per {state, in} combination.
  function automatic int unsigned tbl_depth(input int unsigned state_w);
    return 32'd1 << (state_w + 32'd1);
  endfunction

  // 2-bit state, 2-bit output image: 000/001->11, 010->10, 011->11, 100/101->00, 110/111->10
  localparam logic [15:0] DEFAULT_TABLE = 16'hA0EF;

endpackage

// File: rtl/mealy_out_table.sv
// Output lookup table: synchronous write, asynchronous reset to a fixed image,
// combinational read (a same-cycle read of the written entry returns the old value).
module mealy_out_table #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 8,
  parameter logic [DATA_W*DEPTH-1:0] RESET_IMAGE = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_IMAGE[i*DATA_W +: DATA_W];
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mealy_step_fsm.sv
// Programmable increment/shift Mealy sequencer with load, event flags and a
// saturating step counter; output comes from a runtime-writable table.
module mealy_step_fsm
  import mealy_step_pkg::*;
#(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned CNT_W   = 8,
  parameter bit          REG_OUT = 1'b0,
  parameter logic [OUT_W*tbl_depth(STATE_W)-1:0] RESET_TABLE = DEFAULT_TABLE
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               in_i,
  input  logic               load_i,
  input  logic [STATE_W-1:0] load_val_i,
  input  logic               tbl_we_i,
  input  logic [STATE_W:0]   tbl_addr_i,
  input  logic [OUT_W-1:0]   tbl_data_i,
  output logic [OUT_W-1:0]   out_o,
  output logic [STATE_W-1:0] state_o,
  output logic               wrap_o,
  output logic               zero_o,
  output logic [CNT_W-1:0]   step_cnt_o
);

  localparam int unsigned DEPTH = tbl_depth(STATE_W);

  logic [STATE_W-1:0] state_q, state_d;
  logic               wrap_q, wrap_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   tbl_rd;
  mode_e              mode;

  assign mode = mode_e'(in_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load overrides a step on the same edge, so it also suppresses that step's flags.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    zero_d  = 1'b0;
    cnt_d   = cnt_q;
    if (load_i) begin
      state_d = load_val_i;
      cnt_d   = '0;
    end else if (en_i) begin
      unique case (mode)
        MODE_INC: begin
          state_d = state_q + STATE_W'(1);
          wrap_d  = &state_q;
        end
        MODE_SHL: begin
          state_d = state_q << 1;
          zero_d  = (state_q != '0) && (state_d == '0);
        end
        default: state_d = state_q;
      endcase
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  mealy_out_table #(
    .ADDR_W      (STATE_W + 1),
    .DATA_W      (OUT_W),
    .DEPTH       (DEPTH),
    .RESET_IMAGE (RESET_TABLE)
  ) u_table (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (tbl_we_i),
    .waddr_i (tbl_addr_i),
    .wdata_i (tbl_data_i),
    .raddr_i ({state_q, in_i}),
    .rdata_o (tbl_rd)
  );

  generate
    if (REG_OUT) begin : g_reg_out
      logic [OUT_W-1:0] out_q;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) out_q <= '0;
        else         out_q <= tbl_rd;
      end
      assign out_o = out_q;
    end else begin : g_comb_out
      assign out_o = tbl_rd;
    end
  endgenerate

  assign state_o    = state_q;
  assign wrap_o     = wrap_q;
  assign zero_o     = zero_q;
  assign step_cnt_o = cnt_q;

endmodule

// File: doc/mealy_step_fsm.md
Name: mealy_step_fsm

Overview:
Parametrised successor of the team's 2-bit increment/shift Mealy state machine.
- STATE_W-bit state register; each enabled step increments (in_i=0) or shifts left (in_i=1).
- Mealy output taken from a runtime-writable lookup table indexed by {state, in_i}.
- Adds enable, parallel load, wrap/collapse event flags and a saturating step counter.
- Sits in control paths as a small programmable sequencer/decoder.

Parameters:
STATE_W, 2, state register width (>=1)
OUT_W, 2, output word width (>=1)
CNT_W, 8, step counter width (>=1)
REG_OUT, 0, 0 = combinational Mealy out_o; 1 = out_o registered (one cycle later)
RESET_TABLE, 16'hA0EF, flat table reset image, OUT_W*2^(STATE_W+1) bits; entry i at [i*OUT_W +: OUT_W]; default gives 000/001->11, 010->10, 011->11, 100/101->00, 110/111->10

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
en_i  in  1  step enable
in_i  in  1  step mode: 0 = increment, 1 = shift left (fill 0)
load_i  in  1  parallel load of state
load_val_i  in  STATE_W  load value
tbl_we_i  in  1  table write strobe
tbl_addr_i  in  STATE_W+1  table index {state, in}
tbl_data_i  in  OUT_W  table write data
out_o  out  OUT_W  Mealy output
state_o  out  STATE_W  current state
wrap_o  out  1  one-cycle pulse: increment wrapped all-ones -> 0
zero_o  out  1  one-cycle pulse: shift took a nonzero state to 0
step_cnt_o  out  CNT_W  steps taken, saturating

Behaviour:
- Clock and reset: clk_i clock; reset reset_i, asynchronous, active-high.
- Reset values: state 0, wrap_o 0, zero_o 0, step_cnt_o 0, table = RESET_TABLE.
  - REG_OUT=1: out_o resets to 0.
  - REG_OUT=0: out_o = RESET_TABLE entry {0, in_i}.
- Reset mid-operation: all of the above apply immediately. Any table write in flight is discarded.
- Per-edge priority: load_i > en_i > hold.
  - load_i=1: state <= load_val_i; step_cnt <= 0; no flags raised.
  - en_i=1 and in_i=0: state <= state+1, mod 2^STATE_W. If state was all-ones, wrap_o=1 next cycle.
  - en_i=1 and in_i=1: state <= state<<1, MSB dropped, LSB 0. If state was nonzero and the result is 0, zero_o=1 next cycle.
  - Shift from state 0 stays 0 with no flag.
  - Neither asserted: state holds; flags 0.
- Flags are registered and high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- step_cnt:
  - +1 on each enabled step that is not overridden by load.
  - Saturates at 2^CNT_W-1 and holds there.
  - Cleared by load_i or reset.
- Table:
  - Write on edge: table[tbl_addr_i] <= tbl_data_i. New value is visible from the next cycle.
  - A same-cycle read of the written index returns the old value.
  - Writes are independent of en_i/load_i.
- Output:
  - REG_OUT=0: out_o = table[{state_o, in_i}], purely combinational, with no enable gating.
  - REG_OUT=1: out_o <= table[{state_o, in_i}] on every edge, i.e. one cycle of latency.

Decomposition:
- Package mealy_step_pkg holds:
  - mode enum (MODE_INC=0, MODE_SHL=1);
  - a function computing table depth 2^(STATE_W+1);
  - a default-table localparam.
- One sub-module, mealy_out_table: a register array with synchronous write, asynchronous reset to the image, and a combinational read port.
- State/flag/counter logic stays in the top module.

Test Plan:
- Defaults; reset; en=1, in=0 for 5 cycles:
  - state 0,1,2,3,0,1;
  - out_o 11,10,00,10,11,10;
  - wrap_o high exactly on the cycle state_o shows 0;
  - step_cnt_o=5.
- Load 1; then en=1, in=1:
  - state 1->2->0;
  - zero_o pulses once when state_o=0;
  - a further shift keeps state 0 with no pulse;
  - out_o for {2,1} = 00.
- Same edge load_i=1 (load_val 3), en_i=1, in_i=0:
  - state=3, step_cnt_o=0, wrap_o stays 0.
- At state 1, in=0, write addr 3'b010 data 01:
  - out_o reads 10 during the write cycle and 01 afterwards.
  - Reset restores 10.
- CNT_W=4, 20 enabled steps: step_cnt_o sticks at 15. REG_OUT=1: out_o lags the REG_OUT=0 response by exactly one cycle.
- Assert reset_i asynchronously between edges mid-sequence: state, flags and counter go to 0 immediately, and the table returns to A0EF.
